// File: rtl/prefetcher_pkg.sv
// Shared types and default sizing for the prefetcher data path.
package prefetcher_pkg;

   typedef enum logic [1:0] {
      E_EMPTY   = 2'd0,
      E_PENDING = 2'd1,
      E_READY   = 2'd2
   } pf_entry_state_t;

   localparam int unsigned PF_ADDR_BITS  = 64;
   localparam int unsigned PF_DATA_BITS  = 64;
   localparam int unsigned PF_DEPTH      = 8;
   localparam int unsigned PF_AF_THRESH  = 6;

endpackage

// File: rtl/pf_wrap_ptr.sv
// Circular-buffer pointer with an extra wrap bit so full and empty are distinguishable.
module pf_wrap_ptr #(
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          resetN,
   input  logic          inc,
   input  logic          clr,
   input  logic          clr_to_one,
   output logic [IW-1:0] idx,
   output logic          wrap
);

   logic [IW:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = clr_to_one ? (IW+1)'(1) : '0;
      end else if (inc) begin
         ptr_d = ptr_q + (IW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

   assign idx  = ptr_q[IW-1:0];
   assign wrap = ptr_q[IW];

endmodule

// File: rtl/prefetch_data_queue.sv
// In-order prefetch stream buffer: entries allocated on issue, filled by in-order responses,
// popped when the slave read matches the head. Responses owed to flushed entries are dropped.
module prefetch_data_queue
   import prefetcher_pkg::*;
#(
   parameter int unsigned ADDR_BITS = PF_ADDR_BITS,
   parameter int unsigned DATA_BITS = PF_DATA_BITS,
   parameter int unsigned DEPTH     = PF_DEPTH,
   parameter int unsigned AF_THRESH = PF_AF_THRESH
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   en,
   input  logic                   flushN,
   input  logic                   allocValid,
   input  logic [ADDR_BITS-1:0]   allocAddr,
   output logic                   allocReady,
   input  logic                   respValid,
   input  logic [DATA_BITS-1:0]   respData,
   output logic                   respReady,
   input  logic                   lookupValid,
   input  logic [ADDR_BITS-1:0]   lookupAddr,
   output logic                   prefetcherHit,
   output logic                   rdValid,
   output logic [DATA_BITS-1:0]   rdData,
   input  logic                   rdReady,
   output logic                   almostFull,
   output logic [$clog2(DEPTH):0] outstandingCnt
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;
   localparam int unsigned DW = CW + 3;

   pf_entry_state_t        st_q   [DEPTH];
   pf_entry_state_t        st_d   [DEPTH];
   logic [ADDR_BITS-1:0]   addr_q [DEPTH];
   logic [ADDR_BITS-1:0]   addr_d [DEPTH];
   logic [DATA_BITS-1:0]   data_q [DEPTH];
   logic [DATA_BITS-1:0]   data_d [DEPTH];
   logic [DW-1:0]          drop_q, drop_d;

   logic [IW-1:0] head_idx, tail_idx, fill_idx;
   logic          head_wrap, tail_wrap, fill_wrap;
   logic [CW-1:0] head_ptr, tail_ptr, fill_ptr;
   logic [CW-1:0] occ, pend_cnt;
   logic          empty, full, pend_exist;
   logic          flush, act, alloc_fire, resp_fire, drop_take, fill_fire, pop_fire, resp_used;
   logic [DW:0]   drop_sum, tot;

   assign head_ptr   = {head_wrap, head_idx};
   assign tail_ptr   = {tail_wrap, tail_idx};
   assign fill_ptr   = {fill_wrap, fill_idx};
   assign empty      = (head_ptr == tail_ptr);
   assign full       = (head_idx == tail_idx) && (head_wrap != tail_wrap);
   assign occ        = tail_ptr - head_ptr;
   assign pend_cnt   = tail_ptr - fill_ptr;
   assign pend_exist = (fill_ptr != tail_ptr);

   assign flush      = en && !flushN;
   assign act        = en && flushN;
   assign alloc_fire = act && allocValid && !full;
   assign resp_fire  = en && respValid;
   assign drop_take  = resp_fire && (drop_q != '0);
   assign fill_fire  = act && resp_fire && (drop_q == '0) && pend_exist;
   assign pop_fire   = act && rdValid && rdReady;
   assign resp_used  = resp_fire && ((drop_q != '0) || pend_exist);

   assign allocReady    = !full || !flushN;
   assign respReady     = en;
   assign prefetcherHit = lookupValid && !empty && (addr_q[head_idx] == lookupAddr);
   assign rdValid       = prefetcherHit && (st_q[head_idx] == E_READY);
   assign rdData        = data_q[head_idx];
   assign almostFull    = (occ >= CW'(AF_THRESH));

   // Responses still owed by the interconnect: live PENDING entries plus flushed ones.
   assign tot            = (DW+1)'(pend_cnt) + (DW+1)'(drop_q);
   assign outstandingCnt = (tot >= (DW+1)'(DEPTH)) ? CW'(DEPTH) : CW'(tot);

   // Tail restarts at 1 on a flush with alloc so the demand request becomes entry 0 at the head.
   pf_wrap_ptr #(.DEPTH(DEPTH)) u_head (
      .clk(clk), .resetN(resetN), .inc(pop_fire), .clr(flush), .clr_to_one(1'b0),
      .idx(head_idx), .wrap(head_wrap));
   pf_wrap_ptr #(.DEPTH(DEPTH)) u_tail (
      .clk(clk), .resetN(resetN), .inc(alloc_fire), .clr(flush), .clr_to_one(allocValid),
      .idx(tail_idx), .wrap(tail_wrap));
   pf_wrap_ptr #(.DEPTH(DEPTH)) u_fill (
      .clk(clk), .resetN(resetN), .inc(fill_fire), .clr(flush), .clr_to_one(1'b0),
      .idx(fill_idx), .wrap(fill_wrap));

   always_comb begin
      st_d     = st_q;
      addr_d   = addr_q;
      data_d   = data_q;
      drop_d   = drop_q;
      drop_sum = (DW+1)'(drop_q) + (DW+1)'(pend_cnt) - (DW+1)'(resp_used);
      if (flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) st_d[i] = E_EMPTY;
         if (allocValid) begin
            st_d[0]   = E_PENDING;
            addr_d[0] = allocAddr;
         end
         drop_d = drop_sum[DW] ? '1 : drop_sum[DW-1:0];
      end else if (act) begin
         if (pop_fire) st_d[head_idx] = E_EMPTY;
         if (alloc_fire) begin
            st_d[tail_idx]   = E_PENDING;
            addr_d[tail_idx] = allocAddr;
         end
         if (drop_take) begin
            drop_d = drop_q - DW'(1);
         end else if (fill_fire) begin
            st_d[fill_idx]   = E_READY;
            data_d[fill_idx] = respData;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            st_q[i]   <= E_EMPTY;
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         drop_q <= '0;
      end else begin
         st_q   <= st_d;
         addr_q <= addr_d;
         data_q <= data_d;
         drop_q <= drop_d;
      end
   end

endmodule

// File: tb/tb_prefetch_data_queue.sv
// Directed self-checking bench for prefetch_data_queue (DEPTH=8, AF_THRESH=6).
module tb_prefetch_data_queue;

   logic          clk = 1'b0;
   logic          resetN, en, flushN;
   logic          allocValid, respValid, lookupValid, rdReady;
   logic [63:0]   allocAddr, respData, lookupAddr;
   logic          allocReady, respReady, prefetcherHit, rdValid, almostFull;
   logic [63:0]   rdData;
   logic [3:0]    outstandingCnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prefetch_data_queue #(.ADDR_BITS(64), .DATA_BITS(64), .DEPTH(8), .AF_THRESH(6)) dut (
      .clk(clk), .resetN(resetN), .en(en), .flushN(flushN),
      .allocValid(allocValid), .allocAddr(allocAddr), .allocReady(allocReady),
      .respValid(respValid), .respData(respData), .respReady(respReady),
      .lookupValid(lookupValid), .lookupAddr(lookupAddr),
      .prefetcherHit(prefetcherHit), .rdValid(rdValid), .rdData(rdData), .rdReady(rdReady),
      .almostFull(almostFull), .outstandingCnt(outstandingCnt));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1'b1; flushN = 1'b1;
      allocValid = 1'b0; allocAddr = '0;
      respValid = 1'b0; respData = '0;
      lookupValid = 1'b0; lookupAddr = '0; rdReady = 1'b0;
   endtask

   task automatic do_alloc(input logic [63:0] a);
      allocValid = 1'b1; allocAddr = a;
      step();
      allocValid = 1'b0;
   endtask

   task automatic do_resp(input logic [63:0] d);
      respValid = 1'b1; respData = d;
      step();
      respValid = 1'b0;
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      idle();
      step(); step();
      n_cmp++; if (allocReady !== 1'b1) begin n_err++; $display("FAIL reset_allocReady got=%0b exp=1", allocReady); end
      n_cmp++; if (outstandingCnt !== 4'd0) begin n_err++; $display("FAIL reset_outstanding got=%0d exp=0", outstandingCnt); end
      n_cmp++; if (almostFull !== 1'b0) begin n_err++; $display("FAIL reset_almostFull got=%0b exp=0", almostFull); end
      n_cmp++; if (rdData !== 64'd0) begin n_err++; $display("FAIL reset_rdData got=%h exp=0", rdData); end
      lookupValid = 1'b1; lookupAddr = 64'h0; #1;
      n_cmp++; if (prefetcherHit !== 1'b0 || rdValid !== 1'b0) begin
         n_err++; $display("FAIL reset_hit got=%0b/%0b exp=0/0", prefetcherHit, rdValid); end
      lookupValid = 1'b0;
      resetN = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [63:0] a [3];
      logic [63:0] d [3];
      a[0] = 64'h100; a[1] = 64'h140; a[2] = 64'h180;
      d[0] = 64'hD0D0_0000_0000_0000; d[1] = 64'hD1D1_1111_1111_1111; d[2] = 64'hD2D2_2222_2222_2222;
      for (int i = 0; i < 3; i++) do_alloc(a[i]);
      n_cmp++; if (outstandingCnt !== 4'd3) begin n_err++; $display("FAIL basic_outstanding got=%0d exp=3", outstandingCnt); end
      for (int i = 0; i < 3; i++) do_resp(d[i]);
      n_cmp++; if (outstandingCnt !== 4'd0) begin n_err++; $display("FAIL basic_outstanding_done got=%0d exp=0", outstandingCnt); end
      lookupValid = 1'b1; lookupAddr = a[1]; #1;
      n_cmp++; if (prefetcherHit !== 1'b0) begin n_err++; $display("FAIL basic_nonhead_miss got=%0b exp=0", prefetcherHit); end
      for (int i = 0; i < 3; i++) begin
         lookupAddr = a[i]; rdReady = 1'b1; #1;
         n_cmp++; if (prefetcherHit !== 1'b1 || rdValid !== 1'b1) begin
            n_err++; $display("FAIL basic_hit%0d got=%0b/%0b exp=1/1", i, prefetcherHit, rdValid); end
         n_cmp++; if (rdData !== d[i]) begin n_err++; $display("FAIL basic_data%0d got=%h exp=%h", i, rdData, d[i]); end
         step();
      end
      rdReady = 1'b0; lookupAddr = a[2]; #1;
      n_cmp++; if (prefetcherHit !== 1'b0) begin n_err++; $display("FAIL basic_empty_miss got=%0b exp=0", prefetcherHit); end
      lookupValid = 1'b0;
   endtask

   task automatic test_pending_hit();
      do_alloc(64'h200);
      lookupValid = 1'b1; lookupAddr = 64'h200; #1;
      n_cmp++; if (prefetcherHit !== 1'b1 || rdValid !== 1'b0) begin
         n_err++; $display("FAIL pend_hit got=%0b/%0b exp=1/0", prefetcherHit, rdValid); end
      respValid = 1'b1; respData = 64'h1234_5678_9ABC_DEF0; #1;
      n_cmp++; if (rdValid !== 1'b0) begin n_err++; $display("FAIL pend_same_cycle got=%0b exp=0", rdValid); end
      step();
      respValid = 1'b0;
      n_cmp++; if (rdValid !== 1'b1 || rdData !== 64'h1234_5678_9ABC_DEF0) begin
         n_err++; $display("FAIL pend_fill got=%0b/%h exp=1/123456789abcdef0", rdValid, rdData); end
      rdReady = 1'b1;
      step();
      rdReady = 1'b0; lookupValid = 1'b0;
   endtask

   task automatic test_flush();
      do_alloc(64'h300); do_alloc(64'h340); do_alloc(64'h380);
      flushN = 1'b0; allocValid = 1'b1; allocAddr = 64'h900; #1;
      n_cmp++; if (allocReady !== 1'b1) begin n_err++; $display("FAIL flush_allocReady got=%0b exp=1", allocReady); end
      step();
      flushN = 1'b1; allocValid = 1'b0;
      n_cmp++; if (outstandingCnt !== 4'd4) begin n_err++; $display("FAIL flush_outstanding got=%0d exp=4", outstandingCnt); end
      lookupValid = 1'b1; lookupAddr = 64'h300; #1;
      n_cmp++; if (prefetcherHit !== 1'b0) begin n_err++; $display("FAIL flush_old_miss got=%0b exp=0", prefetcherHit); end
      lookupAddr = 64'h900; #1;
      n_cmp++; if (prefetcherHit !== 1'b1 || rdValid !== 1'b0) begin
         n_err++; $display("FAIL flush_new_head got=%0b/%0b exp=1/0", prefetcherHit, rdValid); end
      for (int i = 0; i < 3; i++) do_resp(64'hBAD0 + 64'(i));
      n_cmp++; if (rdValid !== 1'b0 || outstandingCnt !== 4'd1) begin
         n_err++; $display("FAIL flush_drops got=%0b/%0d exp=0/1", rdValid, outstandingCnt); end
      do_resp(64'h900D);
      n_cmp++; if (rdValid !== 1'b1 || rdData !== 64'h900D) begin
         n_err++; $display("FAIL flush_fill got=%0b/%h exp=1/900d", rdValid, rdData); end
      rdReady = 1'b1;
      step();
      rdReady = 1'b0; lookupValid = 1'b0;
      n_cmp++; if (outstandingCnt !== 4'd0) begin n_err++; $display("FAIL flush_end_outstanding got=%0d exp=0", outstandingCnt); end
   endtask

   task automatic test_almost_full();
      for (int i = 0; i < 5; i++) do_alloc(64'h1000 + 64'(i) * 64'h40);
      n_cmp++; if (almostFull !== 1'b0) begin n_err++; $display("FAIL af_at5 got=%0b exp=0", almostFull); end
      do_alloc(64'h1000 + 64'd5 * 64'h40);
      n_cmp++; if (almostFull !== 1'b1) begin n_err++; $display("FAIL af_at6 got=%0b exp=1", almostFull); end
      for (int i = 0; i < 6; i++) do_resp(64'hD000 + 64'(i));
      lookupValid = 1'b1; lookupAddr = 64'h1000; rdReady = 1'b1;
      step();
      rdReady = 1'b0;
      n_cmp++; if (almostFull !== 1'b0) begin n_err++; $display("FAIL af_after_pop got=%0b exp=0", almostFull); end
      for (int i = 6; i < 8; i++) do_alloc(64'h1000 + 64'(i) * 64'h40);
      n_cmp++; if (allocReady !== 1'b1) begin n_err++; $display("FAIL af_ready_at7 got=%0b exp=1", allocReady); end
      do_alloc(64'h1200);
      n_cmp++; if (allocReady !== 1'b0 || almostFull !== 1'b1) begin
         n_err++; $display("FAIL af_full got=%0b/%0b exp=0/1", allocReady, almostFull); end
      flushN = 1'b0; #1;
      n_cmp++; if (allocReady !== 1'b1) begin n_err++; $display("FAIL af_full_flush_ready got=%0b exp=1", allocReady); end
      flushN = 1'b1;
      do_alloc(64'h1240);
      n_cmp++; if (outstandingCnt !== 4'd3) begin n_err++; $display("FAIL af_ninth_ignored got=%0d exp=3", outstandingCnt); end
      for (int i = 6; i < 9; i++) do_resp(64'hD000 + 64'(i));
      for (int i = 1; i < 9; i++) begin
         lookupAddr = 64'h1000 + 64'(i) * 64'h40; rdReady = 1'b1; #1;
         n_cmp++; if (rdValid !== 1'b1 || rdData !== 64'hD000 + 64'(i)) begin
            n_err++; $display("FAIL af_drain%0d got=%0b/%h exp=1/%h", i, rdValid, rdData, 64'hD000 + 64'(i)); end
         step();
      end
      rdReady = 1'b0; lookupAddr = 64'h1240; #1;
      n_cmp++; if (prefetcherHit !== 1'b0 || outstandingCnt !== 4'd0) begin
         n_err++; $display("FAIL af_empty got=%0b/%0d exp=0/0", prefetcherHit, outstandingCnt); end
      lookupValid = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 22; k++) begin
         allocValid  = (k < 20);
         allocAddr   = 64'h4000 + 64'(k) * 64'h8;
         respValid   = (k >= 1 && k <= 20);
         respData    = 64'hE000 + 64'(k - 1);
         lookupValid = (k >= 2);
         lookupAddr  = 64'h4000 + 64'(k - 2) * 64'h8;
         rdReady     = (k >= 2);
         #1;
         if (k >= 2) begin
            n_cmp++; if (rdValid !== 1'b1 || rdData !== 64'hE000 + 64'(k - 2)) begin
               n_err++; $display("FAIL b2b_pop%0d got=%0b/%h exp=1/%h", k - 2, rdValid, rdData, 64'hE000 + 64'(k - 2)); end
         end
         step();
      end
      idle(); #1;
      n_cmp++; if (outstandingCnt !== 4'd0 || almostFull !== 1'b0) begin
         n_err++; $display("FAIL b2b_end got=%0d/%0b exp=0/0", outstandingCnt, almostFull); end
   endtask

   task automatic test_enable();
      do_alloc(64'h500);
      en = 1'b0; respValid = 1'b1; respData = 64'hAA; allocValid = 1'b1; allocAddr = 64'h540;
      lookupValid = 1'b1; lookupAddr = 64'h500; #1;
      n_cmp++; if (respReady !== 1'b0) begin n_err++; $display("FAIL en_respReady got=%0b exp=0", respReady); end
      n_cmp++; if (prefetcherHit !== 1'b1) begin n_err++; $display("FAIL en_comb_hit got=%0b exp=1", prefetcherHit); end
      step();
      en = 1'b1; respValid = 1'b0; allocValid = 1'b0; #1;
      n_cmp++; if (rdValid !== 1'b0 || outstandingCnt !== 4'd1 || respReady !== 1'b1) begin
         n_err++; $display("FAIL en_frozen got=%0b/%0d/%0b exp=0/1/1", rdValid, outstandingCnt, respReady); end
      do_resp(64'hBB);
      n_cmp++; if (rdValid !== 1'b1 || rdData !== 64'hBB) begin
         n_err++; $display("FAIL en_resume got=%0b/%h exp=1/bb", rdValid, rdData); end
      rdReady = 1'b1;
      step();
      idle();
   endtask

   task automatic test_reset_mid();
      do_alloc(64'h600); do_alloc(64'h640);
      #2 resetN = 1'b0; #1;
      lookupValid = 1'b1; lookupAddr = 64'h600; #1;
      n_cmp++; if (outstandingCnt !== 4'd0 || prefetcherHit !== 1'b0 || allocReady !== 1'b1) begin
         n_err++; $display("FAIL rst_mid got=%0d/%0b/%0b exp=0/0/1", outstandingCnt, prefetcherHit, allocReady); end
      resetN = 1'b1;
      step();
      n_cmp++; if (prefetcherHit !== 1'b0 || rdValid !== 1'b0) begin
         n_err++; $display("FAIL rst_after got=%0b/%0b exp=0/0", prefetcherHit, rdValid); end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_pending_hit();
      test_flush();
      test_almost_full();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
